// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone classic arbiter with registered
// fixed-priority / round-robin grant and an optional bus watchdog.
module wb_arbiter_n #(
  parameter int PORTS        = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH/8,
  parameter     ARB_TYPE     = "PRIORITY",
  parameter     LSB_PRIORITY = "HIGH",
  parameter int TIMEOUT      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [PORTS*DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [PORTS*DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [PORTS-1:0]              wbm_we_i,
  input  logic [PORTS*SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic [PORTS-1:0]              wbm_stb_i,
  input  logic [PORTS-1:0]              wbm_cyc_i,
  output logic [PORTS-1:0]              wbm_ack_o,
  output logic [PORTS-1:0]              wbm_err_o,
  output logic [PORTS-1:0]              wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]         wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]         wbs_dat_i,
  output logic [DATA_WIDTH-1:0]         wbs_dat_o,
  output logic                          wbs_we_o,
  output logic [SELECT_WIDTH-1:0]       wbs_sel_o,
  output logic                          wbs_stb_o,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic                          wbs_cyc_o,
  output logic [PORTS-1:0]              grant_o,
  output logic                          grant_valid_o,
  output logic [$clog2(PORTS)-1:0]      grant_encoded_o,
  output logic                          timeout_o
);

  localparam int IW     = $clog2(PORTS);
  localparam bit RR     = (ARB_TYPE == "ROUND_ROBIN");
  localparam bit LSB_HI = (LSB_PRIORITY == "HIGH");
  localparam bit WD_EN  = (TIMEOUT > 0);
  localparam int CW     = WD_EN ? $clog2(TIMEOUT+1) : 1;
  localparam logic [IW-1:0] LAST_RST = LSB_HI ? IW'(PORTS-1) : '0;

  logic [PORTS-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [PORTS-1:0] rr_mask;
  logic [PORTS-1:0] masked;
  logic [IW-1:0]    win;
  logic             own_cyc;
  logic             own_stb;
  logic             rearb;
  logic             resp;
  logic             wd_fire;

  function automatic logic [IW-1:0] fp_pick(input logic [PORTS-1:0] r);
    logic [IW-1:0] p;
    p = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (LSB_HI) begin
        if (r[PORTS-1-i]) p = IW'(PORTS-1-i);
      end else if (r[i]) begin
        p = IW'(i);
      end
    end
    return p;
  endfunction

  // Round-robin masks off everything up to and including the last winner.
  always_comb begin
    rr_mask = '0;
    for (int i = 0; i < PORTS; i++) begin
      rr_mask[i] = LSB_HI ? (i > int'(last_q)) : (i < int'(last_q));
    end
    masked = wbm_cyc_i & rr_mask;
    if (RR && (|masked)) win = fp_pick(masked);
    else                 win = fp_pick(wbm_cyc_i);
  end

  assign own_cyc = |(grant_q & wbm_cyc_i);
  assign own_stb = |(grant_q & wbm_stb_i);
  assign rearb   = !valid_q || !own_cyc;
  assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;

  assign wbs_cyc_o = valid_q & own_cyc;
  assign wd_fire   = WD_EN && wbs_cyc_o && own_stb &&
                     (cnt_q == CW'(TIMEOUT));
  assign wbs_stb_o = wbs_cyc_o & own_stb & ~wd_fire;

  always_comb begin
    grant_d = grant_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (rearb) begin
      grant_d = '0;
      valid_d = 1'b0;
      idx_d   = '0;
      if (|wbm_cyc_i) begin
        grant_d[win] = 1'b1;
        valid_d      = 1'b1;
        idx_d        = win;
        last_d       = win;
      end
    end
    cnt_d = '0;
    if (WD_EN && wbs_cyc_o && own_stb && !resp && !wd_fire) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q[i]) begin
        wbs_adr_o = wbm_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wbs_dat_o = wbm_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        wbs_sel_o = wbm_sel_i[i*SELECT_WIDTH +: SELECT_WIDTH];
        wbs_we_o  = wbm_we_i[i];
      end
    end
  end

  assign wbm_dat_o = {PORTS{wbs_dat_i}};
  assign wbm_ack_o = grant_q & {PORTS{wbs_ack_i}};
  assign wbm_err_o = grant_q & {PORTS{wbs_err_i | wd_fire}};
  assign wbm_rty_o = grant_q & {PORTS{wbs_rty_i}};

  assign grant_o         = grant_q;
  assign grant_valid_o   = valid_q;
  assign grant_encoded_o = idx_q;
  assign timeout_o       = wd_fire;

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Bench for wb_arbiter_n: three configurations driven in lockstep,
// per-cycle expectations queued and checked by a negedge monitor.
module tb_wb_arbiter_n;

  localparam int P  = 4;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [P*32-1:0] m_adr[NI], m_dat[NI], m_dato[NI];
  logic [P*4-1:0]  m_sel[NI];
  logic [P-1:0]    m_we[NI], m_stb[NI], m_cyc[NI];
  logic [P-1:0]    m_ack[NI], m_err[NI], m_rty[NI];
  logic [31:0]     s_adr[NI], s_dati[NI], s_dato[NI];
  logic [3:0]      s_sel[NI];
  logic            s_we[NI], s_stb[NI], s_cyc[NI];
  logic            s_ack[NI], s_err[NI], s_rty[NI];
  logic [P-1:0]    gnt[NI];
  logic            gv[NI], tmo[NI];
  logic [1:0]      genc[NI];

  wb_arbiter_n #(.PORTS(P), .ARB_TYPE("PRIORITY"), .LSB_PRIORITY("HIGH"),
    .TIMEOUT(8)) u_p (
    .clk(clk), .rst(rst),
    .wbm_adr_i(m_adr[0]), .wbm_dat_i(m_dat[0]), .wbm_dat_o(m_dato[0]),
    .wbm_we_i(m_we[0]), .wbm_sel_i(m_sel[0]), .wbm_stb_i(m_stb[0]),
    .wbm_cyc_i(m_cyc[0]), .wbm_ack_o(m_ack[0]), .wbm_err_o(m_err[0]),
    .wbm_rty_o(m_rty[0]), .wbs_adr_o(s_adr[0]), .wbs_dat_i(s_dati[0]),
    .wbs_dat_o(s_dato[0]), .wbs_we_o(s_we[0]), .wbs_sel_o(s_sel[0]),
    .wbs_stb_o(s_stb[0]), .wbs_ack_i(s_ack[0]), .wbs_err_i(s_err[0]),
    .wbs_rty_i(s_rty[0]), .wbs_cyc_o(s_cyc[0]), .grant_o(gnt[0]),
    .grant_valid_o(gv[0]), .grant_encoded_o(genc[0]), .timeout_o(tmo[0]));

  wb_arbiter_n #(.PORTS(P), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("HIGH"),
    .TIMEOUT(0)) u_rr (
    .clk(clk), .rst(rst),
    .wbm_adr_i(m_adr[1]), .wbm_dat_i(m_dat[1]), .wbm_dat_o(m_dato[1]),
    .wbm_we_i(m_we[1]), .wbm_sel_i(m_sel[1]), .wbm_stb_i(m_stb[1]),
    .wbm_cyc_i(m_cyc[1]), .wbm_ack_o(m_ack[1]), .wbm_err_o(m_err[1]),
    .wbm_rty_o(m_rty[1]), .wbs_adr_o(s_adr[1]), .wbs_dat_i(s_dati[1]),
    .wbs_dat_o(s_dato[1]), .wbs_we_o(s_we[1]), .wbs_sel_o(s_sel[1]),
    .wbs_stb_o(s_stb[1]), .wbs_ack_i(s_ack[1]), .wbs_err_i(s_err[1]),
    .wbs_rty_i(s_rty[1]), .wbs_cyc_o(s_cyc[1]), .grant_o(gnt[1]),
    .grant_valid_o(gv[1]), .grant_encoded_o(genc[1]), .timeout_o(tmo[1]));

  wb_arbiter_n #(.PORTS(P), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("LOW"),
    .TIMEOUT(3)) u_rl (
    .clk(clk), .rst(rst),
    .wbm_adr_i(m_adr[2]), .wbm_dat_i(m_dat[2]), .wbm_dat_o(m_dato[2]),
    .wbm_we_i(m_we[2]), .wbm_sel_i(m_sel[2]), .wbm_stb_i(m_stb[2]),
    .wbm_cyc_i(m_cyc[2]), .wbm_ack_o(m_ack[2]), .wbm_err_o(m_err[2]),
    .wbm_rty_o(m_rty[2]), .wbs_adr_o(s_adr[2]), .wbs_dat_i(s_dati[2]),
    .wbs_dat_o(s_dato[2]), .wbs_we_o(s_we[2]), .wbs_sel_o(s_sel[2]),
    .wbs_stb_o(s_stb[2]), .wbs_ack_i(s_ack[2]), .wbs_err_i(s_err[2]),
    .wbs_rty_i(s_rty[2]), .wbs_cyc_o(s_cyc[2]), .grant_o(gnt[2]),
    .grant_valid_o(gv[2]), .grant_encoded_o(genc[2]), .timeout_o(tmo[2]));

  // Per-instance configuration, mirrored from the instance parameters.
  int TMO[NI]  = '{8, 0, 3};
  bit RRB[NI]  = '{1'b0, 1'b1, 1'b1};
  bit LOWB[NI] = '{1'b0, 1'b0, 1'b1};

  typedef struct {
    int              d;
    logic [P-1:0]    gnt;
    logic            gv;
    logic [1:0]      enc;
    logic            cyc, stb, we, tmo;
    logic [31:0]     adr, dat;
    logic [3:0]      sel;
    logic [P-1:0]    ack, err, rty;
    logic [P*32-1:0] mdat;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference state: who owns the bus, last winner, stall cycles.
  int owner[NI], last[NI], stall[NI], swait[NI];
  int mmode[NI], smode[NI], slat[NI];
  bit force_ack[NI];
  logic [P-1:0] got_resp[NI];
  logic nx_rst;
  logic [P-1:0]    nx_cyc[NI], nx_stb[NI], nx_we[NI];
  logic [P*32-1:0] nx_adr[NI], nx_dat[NI];
  logic [P*4-1:0]  nx_sel[NI];

  int order[$];
  int prev;
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string nm, input int d,
                     input logic [127:0] a, input logic [127:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h want %0h @%0t", nm, d, a, x, $time);
    end
  endtask

  // Winner search: walk indices in priority order, starting just past
  // the previous winner when round-robin has a history.
  function automatic int pick(input int d, input logic [P-1:0] r);
    int st, k;
    if (RRB[d] && last[d] >= 0) st = LOWB[d] ? last[d] - 1 : last[d] + 1;
    else                        st = LOWB[d] ? P - 1 : 0;
    for (int n = 0; n < P; n++) begin
      k = LOWB[d] ? st - n : st + n;
      k = ((k % P) + P) % P;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive_masters(input int d);
    if (mmode[d] == 0) begin
      m_cyc[d] = nx_cyc[d]; m_stb[d] = nx_stb[d]; m_we[d] = nx_we[d];
      m_adr[d] = nx_adr[d]; m_dat[d] = nx_dat[d]; m_sel[d] = nx_sel[d];
    end else begin
      for (int i = 0; i < P; i++) begin
        if (mmode[d] == 1) begin
          m_cyc[d][i] = !got_resp[d][i];
          m_stb[d][i] = !got_resp[d][i];
          m_adr[d][i*32 +: 32] = 32'h100 * i;
        end else if (!m_cyc[d][i] || got_resp[d][i]) begin
          if (m_cyc[d][i] && $urandom_range(1) == 0) begin
            m_cyc[d][i] = 1'b0;
            m_stb[d][i] = 1'b0;
          end else if (m_cyc[d][i] || $urandom_range(2) == 0) begin
            m_cyc[d][i] = 1'b1;
            m_stb[d][i] = 1'b1;
            m_we[d][i]  = 1'($urandom);
            m_adr[d][i*32 +: 32] = $urandom;
            m_dat[d][i*32 +: 32] = $urandom;
            m_sel[d][i*4 +: 4]   = 4'($urandom);
          end
        end else begin
          m_stb[d][i] = ($urandom_range(7) != 0);
        end
      end
    end
  endtask

  task automatic drive_slave(input int d, input bit act, input bit gvld);
    int r;
    s_ack[d] = 1'b0; s_err[d] = 1'b0; s_rty[d] = 1'b0;
    if (act && smode[d] != 0) begin
      if (swait[d] >= slat[d]) begin
        swait[d] = 0;
        r = (smode[d] == 2) ? $urandom_range(9) : 9;
        if (r == 0)      s_err[d] = 1'b1;
        else if (r == 1) s_rty[d] = 1'b1;
        else             s_ack[d] = 1'b1;
        if (smode[d] == 2) slat[d] = $urandom_range(5);
      end else begin
        swait[d]++;
      end
    end else begin
      swait[d] = 0;
      if (smode[d] == 2 && !gvld && $urandom_range(7) == 0) s_ack[d] = 1'b1;
    end
    if (force_ack[d]) s_ack[d] = 1'b1;
  endtask

  task automatic step();
    exp_t e;
    int g, w;
    bit ocyc, ostb, fire, rsp;
    @(posedge clk);
    #1;
    rst = nx_rst;
    for (int d = 0; d < NI; d++) begin
      drive_masters(d);
      g = owner[d];
      ocyc = (g >= 0) && m_cyc[d][g];
      ostb = (g >= 0) && m_stb[d][g];
      fire = (TMO[d] > 0) && ocyc && ostb && (stall[d] == TMO[d]);
      drive_slave(d, ocyc && ostb && !fire, g >= 0);
      s_dati[d] = $urandom;
      e.d    = d;
      e.gv   = (g >= 0);
      e.gnt  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      e.enc  = (g >= 0) ? 2'(g) : 2'd0;
      e.cyc  = ocyc;
      e.stb  = ocyc && ostb && !fire;
      e.tmo  = fire;
      e.adr  = (g >= 0) ? m_adr[d][g*32 +: 32] : 32'h0;
      e.dat  = (g >= 0) ? m_dat[d][g*32 +: 32] : 32'h0;
      e.sel  = (g >= 0) ? m_sel[d][g*4 +: 4] : 4'h0;
      e.we   = (g >= 0) && m_we[d][g];
      e.ack  = ((g >= 0) && s_ack[d]) ? e.gnt : 4'b0000;
      e.err  = ((g >= 0) && (s_err[d] || fire)) ? e.gnt : 4'b0000;
      e.rty  = ((g >= 0) && s_rty[d]) ? e.gnt : 4'b0000;
      e.mdat = {P{s_dati[d]}};
      q.push_back(e);
      got_resp[d] = e.ack | e.err | e.rty;
      if (rst) begin
        owner[d] = -1; last[d] = -1; stall[d] = 0;
      end else begin
        rsp = s_ack[d] || s_err[d] || s_rty[d];
        stall[d] = (ocyc && ostb && !rsp && !fire) ? stall[d] + 1 : 0;
        if (g < 0 || !m_cyc[d][g]) begin
          w = pick(d, m_cyc[d]);
          owner[d] = w;
          if (w >= 0) last[d] = w;
        end
      end
    end
  endtask

  task automatic idle_inst(input int d);
    mmode[d] = 0; smode[d] = 0; force_ack[d] = 1'b0;
    nx_cyc[d] = '0; nx_stb[d] = '0; nx_we[d] = '0;
    nx_adr[d] = '0; nx_dat[d] = '0; nx_sel[d] = '0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      me = q.pop_front();
      chk("grant_o", me.d, gnt[me.d], me.gnt);
      chk("grant_valid_o", me.d, gv[me.d], me.gv);
      chk("grant_encoded_o", me.d, genc[me.d], me.enc);
      chk("wbs_cyc_o", me.d, s_cyc[me.d], me.cyc);
      chk("wbs_stb_o", me.d, s_stb[me.d], me.stb);
      chk("wbs_adr_o", me.d, s_adr[me.d], me.adr);
      chk("wbs_dat_o", me.d, s_dato[me.d], me.dat);
      chk("wbs_sel_o", me.d, s_sel[me.d], me.sel);
      chk("wbs_we_o", me.d, s_we[me.d], me.we);
      chk("wbm_ack_o", me.d, m_ack[me.d], me.ack);
      chk("wbm_err_o", me.d, m_err[me.d], me.err);
      chk("wbm_rty_o", me.d, m_rty[me.d], me.rty);
      chk("timeout_o", me.d, tmo[me.d], me.tmo);
      chk("wbm_dat_o", me.d, m_dato[me.d], me.mdat);
    end
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: run did not complete");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    rst = 1'b1;
    nx_rst = 1'b1;
    for (int d = 0; d < NI; d++) begin
      idle_inst(d);
      owner[d] = -1; last[d] = -1; stall[d] = 0; swait[d] = 0;
      slat[d] = 0; got_resp[d] = '0;
      m_cyc[d] = '0; m_stb[d] = '0; m_we[d] = '0;
      m_adr[d] = '0; m_dat[d] = '0; m_sel[d] = '0;
      s_ack[d] = 1'b0; s_err[d] = 1'b0; s_rty[d] = 1'b0; s_dati[d] = '0;
    end
    repeat (3) @(posedge clk);
    step(); #5;
    chk("reset_grant_valid", 0, gv[0], 0);
    chk("reset_wbs_cyc", 0, s_cyc[0], 0);
    nx_rst = 1'b0;

    // Fixed priority: 1 and 3 request together, 1 wins, 3 on handover.
    nx_cyc[0] = 4'b1010; nx_stb[0] = 4'b1010;
    step();
    step(); #5;
    chk("pri_first_grant", 0, gnt[0], 4'b0010);
    nx_cyc[0] = 4'b1000; nx_stb[0] = 4'b1000;
    step(); #5;
    chk("pri_hold_grant", 0, gnt[0], 4'b0010);
    step(); #5;
    chk("pri_handover", 0, gnt[0], 4'b1000);
    chk("pri_handover_enc", 0, genc[0], 3);
    idle_inst(0);
    step(); step();

    // Round-robin rotation with every master re-requesting.
    mmode[1] = 1; smode[1] = 1; slat[1] = 0;
    prev = -1;
    for (int n = 0; n < 40 && order.size() < 5; n++) begin
      step(); #5;
      if (s_cyc[1] && int'(genc[1]) != prev) begin
        prev = int'(genc[1]);
        order.push_back(prev);
      end
    end
    chk("rr_grant_count", 1, order.size(), 5);
    for (int k = 0; k < order.size() && k < 5; k++)
      chk("rr_order", 1, order[k], rr_exp[k]);
    idle_inst(1);
    step(); step();

    // Directed write from master 2, slave acks 3 cycles after stb.
    nx_cyc[0] = 4'b0100; nx_stb[0] = 4'b0100; nx_we[0] = 4'b0100;
    nx_adr[0][2*32 +: 32] = 32'h0000_1000;
    nx_dat[0][2*32 +: 32] = 32'hDEAD_BEEF;
    nx_sel[0][2*4 +: 4]   = 4'hF;
    smode[0] = 1; slat[0] = 3;
    step();
    step(); #5;
    chk("wr_adr", 0, s_adr[0], 32'h0000_1000);
    chk("wr_dat", 0, s_dato[0], 32'hDEAD_BEEF);
    chk("wr_sel", 0, s_sel[0], 4'hF);
    chk("wr_we", 0, s_we[0], 1);
    chk("wr_stb", 0, s_stb[0], 1);
    for (int k = 0; k < 2; k++) begin
      step(); #5;
      chk("wr_no_ack_yet", 0, m_ack[0], 4'b0000);
    end
    step(); #5;
    chk("wr_ack_only_m2", 0, m_ack[0], 4'b0100);
    idle_inst(0);
    step(); step();

    // Watchdog: silent slave, fire 8 cycles after stb.
    nx_cyc[0] = 4'b0001; nx_stb[0] = 4'b0001;
    step();
    for (int k = 0; k < 8; k++) begin
      step(); #5;
      chk("wd_quiet", 0, tmo[0], 0);
    end
    step(); #5;
    chk("wd_fire", 0, tmo[0], 1);
    chk("wd_err", 0, m_err[0], 4'b0001);
    chk("wd_stb_suppressed", 0, s_stb[0], 0);
    step(); #5;
    chk("wd_rearm", 0, tmo[0], 0);
    chk("wd_stb_back", 0, s_stb[0], 1);
    idle_inst(0);
    step(); step();

    // Reset in the middle of a cycle, then a late ack.
    nx_cyc[0] = 4'b0001; nx_stb[0] = 4'b0001;
    step();
    step(); #5;
    chk("pre_rst_cyc", 0, s_cyc[0], 1);
    nx_rst = 1'b1;
    step();
    nx_rst = 1'b0;
    force_ack[0] = 1'b1;
    step(); #5;
    chk("post_rst_gv", 0, gv[0], 0);
    chk("post_rst_cyc", 0, s_cyc[0], 0);
    chk("post_rst_ack", 0, m_ack[0], 4'b0000);
    idle_inst(0);
    step(); step();

    // Random traffic on all three configurations.
    for (int d = 0; d < NI; d++) begin
      mmode[d] = 2; smode[d] = 2; slat[d] = $urandom_range(5);
    end
    repeat (3000) step();
    for (int d = 0; d < NI; d++) idle_inst(d);
    repeat (3) step();
    @(negedge clk); #1;
    chk("queue_drained", 0, q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
